// File: rtl/aq_idu_id_wbt_pentry.sv
// Write-back table entry: counts outstanding producers of one destination and
// reports ready/near-ready status. Optional counter-misuse flag under AQ_IDU_WBT_ERR_CHK_EN.
module aq_idu_id_wbt_pentry #(
    parameter int CRT_PORTS = 2,
    parameter int WB_PORTS  = 2,
    parameter int CNT_W     = 2,
    parameter int TYPE_W    = 3
) (
    input  logic                        wb_clk,
    input  logic                        cpurst,
    input  logic [CRT_PORTS-1:0]        create_en_x,
    input  logic [CRT_PORTS*TYPE_W-1:0] dp_wbt_dst_type,
    input  logic                        iu_yy_xx_cancel,
    input  logic                        rtu_idu_flush_wbt,
    input  logic [WB_PORTS-1:0]         wb_en_x,
    output logic [CNT_W+TYPE_W+1:0]     read_data_y,
    output logic                        full_x,
    output logic                        wb_debug_x,
    output logic                        err_x
);

    localparam int K_W = $clog2(WB_PORTS + 1);
    // Two guard bits so pend + create and pend - k never alias into valid counts.
    localparam int C_W = ((CNT_W > K_W) ? CNT_W : K_W) + 2;
    localparam logic [CNT_W-1:0] PMAX = '1;

    logic [CNT_W-1:0]  r_pend;
    logic [TYPE_W-1:0] r_type;
    logic              r_wb;

    logic              w_create;
    logic [TYPE_W-1:0] w_type_sel;
    logic [C_W-1:0]    w_pend_ext;
    logic [C_W-1:0]    w_k_raw;
    logic [C_W-1:0]    w_k;
    logic [C_W-1:0]    w_k_use;
    logic [C_W-1:0]    w_sum;
    logic [C_W-1:0]    w_rem;
    logic [CNT_W-1:0]  w_pend_nxt;
    logic              w_vld;
    logic              w_near_vld;

    assign w_create = (|create_en_x) & ~iu_yy_xx_cancel;

    // Lowest-index asserted port wins: iterate high to low so it is assigned last.
    always_comb begin
        w_type_sel = '0;
        for (int i = CRT_PORTS - 1; i >= 0; i--) begin
            if (create_en_x[i]) begin
                w_type_sel = dp_wbt_dst_type[i*TYPE_W +: TYPE_W];
            end
        end
    end

    always_comb begin
        w_k_raw = '0;
        for (int i = 0; i < WB_PORTS; i++) begin
            w_k_raw = w_k_raw + C_W'(wb_en_x[i]);
        end
    end

    assign w_pend_ext = C_W'(r_pend);
    assign w_k        = (r_pend != '0) ? w_k_raw : '0;
    assign w_k_use    = (w_k > w_pend_ext) ? w_pend_ext : w_k;
    assign w_sum      = w_pend_ext + C_W'(w_create) - w_k_use;
    assign w_pend_nxt = (w_sum > C_W'(PMAX)) ? PMAX : w_sum[CNT_W-1:0];
    assign w_rem      = w_pend_ext - w_k;

    // Bypass the final write-back so consumers see ready in the same cycle.
    assign w_vld      = r_wb | (~w_create & (w_k != '0) & (w_k == w_pend_ext));
    assign w_near_vld = (w_k != '0) & (w_rem == C_W'(1));

    always_ff @(posedge wb_clk or posedge cpurst) begin
        if (cpurst) begin
            r_pend <= '0;
            r_type <= '0;
            r_wb   <= 1'b1;
        end else if (rtu_idu_flush_wbt) begin
            r_pend <= '0;
            r_type <= '0;
            r_wb   <= 1'b1;
        end else begin
            r_pend <= w_pend_nxt;
            r_wb   <= (w_pend_nxt == '0);
            if (w_create) begin
                r_type <= w_type_sel;
            end
        end
    end

`ifdef AQ_IDU_WBT_ERR_CHK_EN
    logic r_err;
    logic w_ovf;
    logic w_unf;

    assign w_ovf = w_create & (r_pend == PMAX) & (w_k == '0);
    assign w_unf = (w_k_raw > w_pend_ext);

    always_ff @(posedge wb_clk or posedge cpurst) begin
        if (cpurst) begin
            r_err <= 1'b0;
        end else if (rtu_idu_flush_wbt) begin
            r_err <= 1'b0;
        end else if (w_ovf | w_unf) begin
            r_err <= 1'b1;
        end
    end

    assign err_x = r_err;
`else
    assign err_x = 1'b0;
`endif

    assign read_data_y = {r_pend, r_type, w_near_vld, w_vld};
    assign full_x      = (r_pend == PMAX);
    assign wb_debug_x  = r_wb;

endmodule
